vga_scan_gen: RTL and testbench
===============================

Name: vga_scan_gen

Overview:
- Generates VGA raster timing for the tank game: walks the screen, drives pixel_x/pixel_y into the game logic, and receives the resulting 1-bit r/g/b from the pixel-colour stage after a fixed RAM latency.
- Re-aligns sync and blanking with that delayed colour, then drives the VGA pins.
- 640x480@60 from a 100 MHz clk using a /4 pixel enable.

Parameters:
CLK_DIV, 4, clk cycles per pixel; legal values 1 and up.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch (pixels).
H_SYNC, 96, hsync width (pixels).
H_BP, 48, horizontal back porch (pixels).
V_ACTIVE, 480, visible lines.
V_FP, 10, vertical front porch (lines).
V_SYNC, 2, vsync width (lines).
V_BP, 33, vertical back porch (lines).
PIPE_LAT, 2, pixel ticks from pixel_x/pixel_y to valid r_in/g_in/b_in; legal range 0..4.
SYNC_POL, 0, sync active level; 0 means active-low.

Ports:
clk  input  1  system clock
RSTN  input  1  asynchronous reset, active-low
r_in  input  1  red from colour stage, PIPE_LAT ticks behind pixel_x/pixel_y
g_in  input  1  green, same timing as r_in
b_in  input  1  blue, same timing as r_in
pixel_x  output  10  current horizontal count (0..H_TOTAL-1)
pixel_y  output  10  current vertical count (0..V_TOTAL-1)
pixel_tick  output  1  one-clk pixel enable
frame_start  output  1  one-clk pulse at frame wrap
r  output  1  VGA red
g  output  1  VGA green
b  output  1  VGA blue
hsync  output  1  VGA horizontal sync
vsync  output  1  VGA vertical sync

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525). Both must be 1024 or less.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pixel_tick = 1 when div_cnt == CLK_DIV-1. With CLK_DIV=1, pixel_tick is constant 1 out of reset.
- Horizontal counter: on pixel_tick, h_cnt increments and wraps at H_TOTAL-1 to 0.
- Vertical counter: v_cnt increments on the h wrap and wraps at V_TOTAL-1 to 0.
- pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the counter registers. Off-screen values are visible to the game logic.
- Raw attributes, per counter position:
  - hs_raw active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs_raw active for v in [490, 491].
  - vid_raw = (h < H_ACTIVE) && (v < V_ACTIVE).
- Alignment pipeline: hs/vs/vid go through a PIPE_LAT-stage shift register that advances only on pixel_tick.
- Output register, loaded on pixel_tick:
  - hsync and vsync take the delayed hs/vs, driven at the SYNC_POL level.
  - r/g/b = delayed vid ? {r_in,g_in,b_in} : 0.
- Latency: everything for position (x,y) appears on the pins exactly PIPE_LAT+1 ticks after pixel_x/pixel_y first show (x,y). r_in/g_in/b_in are sampled on the tick PIPE_LAT ticks after that position.
- frame_start: high for exactly one clk on the cycle the counters step from (H_TOTAL-1, V_TOTAL-1) to (0,0). Not asserted on reset exit.
- Reset (RSTN low, async):
  - div_cnt, h_cnt, v_cnt = 0; pixel_tick = 0; frame_start = 0.
  - r, g, b = 0; hsync and vsync at the inactive level (1 when SYNC_POL=0).
  - All pipeline stages cleared to inactive/blank.
- Reset mid-line or mid-frame: the raster restarts from (0,0). No partial sync pulse may remain asserted.
- Release: the first pixel_tick occurs CLK_DIV clk cycles after RSTN deasserts.

Optional Feature:
- VGA_BORDER_TEST_EN defined:
  - A border flag (x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1, inside the active area) is computed from the raw counters.
  - The flag is delayed through the same pipeline as vid.
  - When the delayed flag is set, r=g=b=1 regardless of the inputs.
- Undefined: no border logic is present; r/g/b come purely from the inputs and the blanking mask.

Test Plan:
- Reset mid-line: pull RSTN low at h=300. Required: immediately pixel_x=0, pixel_y=0, hsync=vsync=1, r/g/b=0. After release, first pixel_tick 4 clks later.
- Line timing: measure hsync. Required: falling-edge period 3200 clk, low width 384 clk.
- Frame timing: measure vsync. Required: period 1,680,000 clk, low width 6400 clk. frame_start exactly once per period, coincident with the (799,524) to (0,0) step.
- Pipeline alignment, PIPE_LAT=2: bench RAM returns r = (x==5) delayed 2 ticks. Required: r high for exactly 4 clk, starting 3 ticks after pixel_x=5. hsync falls 3 ticks after pixel_x=656.
- Blanking: hold r_in=g_in=b_in=1. Required: 640 high pixels per line on lines 0..479; zero on x≥640 positions and on lines ≥480.
- With VGA_BORDER_TEST_EN and inputs held 0: r/g/b=1 only on pixels x=0, x=639, y=0 and y=479. All other pixels are 0.

Source files
------------

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator with sync/blank re-alignment to a delayed colour stage.
// Optional define VGA_BORDER_TEST_EN forces a white frame around the active area.
module vga_scan_gen #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned PIPE_LAT = 2,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       RSTN,
   input  logic       r_in,
   input  logic       g_in,
   input  logic       b_in,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       pixel_tick,
   output logic       frame_start,
   output logic       r,
   output logic       g,
   output logic       b,
   output logic       hsync,
   output logic       vsync
);

   localparam int unsigned CNT_W    = 10;
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

   localparam int unsigned A_HS  = 0;
   localparam int unsigned A_VS  = 1;
   localparam int unsigned A_VID = 2;
`ifdef VGA_BORDER_TEST_EN
   localparam int unsigned A_BRD  = 3;
   localparam int unsigned ATTR_W = 4;
`else
   localparam int unsigned ATTR_W = 3;
`endif

   logic [DIV_W-1:0]  div_cnt;
   logic              div_wrap;
   logic [CNT_W-1:0]  h_cnt;
   logic [CNT_W-1:0]  v_cnt;
   logic              h_last;
   logic              v_last;
   logic [ATTR_W-1:0] attr_raw;
   logic [ATTR_W-1:0] attr_dly;
   logic [2:0]        rgb_nxt;

   assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign h_last   = (h_cnt == CNT_W'(H_TOTAL - 1));
   assign v_last   = (v_cnt == CNT_W'(V_TOTAL - 1));
   assign pixel_x  = h_cnt;
   assign pixel_y  = v_cnt;

   // Pixel enable: registered so it is low in reset and first fires CLK_DIV clks after release.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         div_cnt    <= '0;
         pixel_tick <= 1'b0;
      end else begin
         div_cnt    <= div_wrap ? '0 : div_cnt + DIV_W'(1);
         pixel_tick <= div_wrap;
      end
   end

   // Raster counters; frame_start marks the cycle the counters land on (0,0).
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pixel_tick && h_last && v_last;
         if (pixel_tick) begin
            if (h_last) begin
               h_cnt <= '0;
               v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
            end else begin
               h_cnt <= h_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Active-high attributes of the current counter position.
   always_comb begin
      attr_raw        = '0;
      attr_raw[A_HS]  = (h_cnt >= CNT_W'(HS_START)) && (h_cnt <= CNT_W'(HS_END));
      attr_raw[A_VS]  = (v_cnt >= CNT_W'(VS_START)) && (v_cnt <= CNT_W'(VS_END));
      attr_raw[A_VID] = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
`ifdef VGA_BORDER_TEST_EN
      attr_raw[A_BRD] = attr_raw[A_VID] &&
                        ((h_cnt == '0) || (h_cnt == CNT_W'(H_ACTIVE - 1)) ||
                         (v_cnt == '0) || (v_cnt == CNT_W'(V_ACTIVE - 1)));
`endif
   end

   // Delay attributes to line up with the colour returned by the RAM stage.
   if (PIPE_LAT == 0) begin : g_nopipe
      assign attr_dly = attr_raw;
   end else begin : g_pipe
      logic [PIPE_LAT-1:0][ATTR_W-1:0] stage;

      always_ff @(posedge clk or negedge RSTN) begin
         if (!RSTN) begin
            stage <= '0;
         end else if (pixel_tick) begin
            stage[0] <= attr_raw;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
               stage[i] <= stage[i-1];
            end
         end
      end

      assign attr_dly = stage[PIPE_LAT-1];
   end

   always_comb begin
      rgb_nxt = 3'b000;
      if (attr_dly[A_VID]) begin
         rgb_nxt = {r_in, g_in, b_in};
      end
`ifdef VGA_BORDER_TEST_EN
      if (attr_dly[A_BRD]) begin
         rgb_nxt = 3'b111;
      end
`endif
   end

   // Pin register: reset drives syncs to their inactive level so no partial pulse survives.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         r     <= 1'b0;
         g     <= 1'b0;
         b     <= 1'b0;
         hsync <= ~SYNC_POL;
         vsync <= ~SYNC_POL;
      end else if (pixel_tick) begin
         {r, g, b} <= rgb_nxt;
         hsync     <= attr_dly[A_HS] ? SYNC_POL : ~SYNC_POL;
         vsync     <= attr_dly[A_VS] ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen on a shrunken 16x6 raster (25x10 totals, /4 divider, PIPE_LAT=2).
// Honours VGA_BORDER_TEST_EN when the design is built with it.
module tb_vga_scan_gen;

   localparam int unsigned H_ACT = 16;
   localparam int unsigned V_ACT = 6;

   logic       clk = 1'b0;
   logic       RSTN;
   logic       r_in, g_in, b_in;
   logic [9:0] pixel_x, pixel_y;
   logic       pixel_tick, frame_start;
   logic       r, g, b, hsync, vsync;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int mode       = 1;
   logic p1 = 1'b0;
   logic p2 = 1'b0;

   int n, t0, t1, t_f1, t_r, t_f2, cnt, bad, fs_cnt, fs_bad, pix_err, lit;
   logic prev_s;
   logic [9:0] prev_x, prev_y;

   vga_scan_gen #(
      .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIPE_LAT(2), .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .RSTN(RSTN), .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_tick(pixel_tick),
      .frame_start(frame_start), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
   );

   always #5 clk = ~clk;

   // Two-tick colour RAM stand-in: red is lit for column 5 only.
   always @(posedge clk) begin
      if (pixel_tick) begin
         p1 <= (pixel_x == 10'd5);
         p2 <= p1;
      end
   end

   assign r_in = (mode == 1) ? 1'b1 : ((mode == 0) ? p2 : 1'b0);
   assign g_in = (mode == 1);
   assign b_in = (mode == 1);

   task automatic check(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic exp_pix(input logic [9:0] x, input logic [9:0] y, input int m);
      logic vid;
      vid = (x < 10'(H_ACT)) && (y < 10'(V_ACT));
      if (m == 1) return vid;
`ifdef VGA_BORDER_TEST_EN
      return vid && (x == 10'd0 || x == 10'(H_ACT - 1) || y == 10'd0 || y == 10'(V_ACT - 1));
`else
      return 1'b0;
`endif
   endfunction

   // Aligns to frame_start, then checks every pixel of one frame against a 3-tick-delayed model.
   task automatic run_frame(input int m, output int err, output int nlit);
      logic [2:0] hist;
      logic       e;
      err  = 0;
      nlit = 0;
      hist = 3'b000;
      for (int i = 0; i < 1200 && !frame_start; i++) step();
      if (!frame_start) err = 9999;
      mode = m;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (pixel_tick) begin
            e = hist[2];
            if ({r, g, b} !== {3{e}}) err++;
            if (r) nlit++;
            hist = {hist[1:0], exp_pix(pixel_x, pixel_y, m)};
         end
      end
   endtask

   initial begin
      // Reset values
      mode = 1;
      RSTN = 1'b0;
      repeat (3) step();
      check("rst_pixel_x", int'(pixel_x), 0);
      check("rst_pixel_y", int'(pixel_y), 0);
      check("rst_tick", int'(pixel_tick), 0);
      check("rst_frame_start", int'(frame_start), 0);
      check("rst_hsync", int'(hsync), 1);
      check("rst_vsync", int'(vsync), 1);
      check("rst_rgb", int'({r, g, b}), 0);

      // Release: first tick 4 clks later, no frame_start on exit
      RSTN = 1'b1;
      fs_cnt = 0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (frame_start) fs_cnt++;
         if (pixel_tick) begin n = i; break; end
      end
      check("first_tick_delay", n, 4);
      check("no_fs_on_release", fs_cnt, 0);
      check("tick_pixel_x", int'(pixel_x), 0);
      step();
      check("after_tick_pixel_x", int'(pixel_x), 1);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (pixel_tick) begin n = i; break; end
      end
      check("tick_period", n, 3);

      // Mid-line reset while hsync is active
      for (int i = 0; i < 200 && pixel_x != 10'd22; i++) step();
      check("pre_reset_hsync_low", int'(hsync), 0);
      #2;
      RSTN = 1'b0;
      #1;
      check("midrst_pixel_x", int'(pixel_x), 0);
      check("midrst_pixel_y", int'(pixel_y), 0);
      check("midrst_hsync", int'(hsync), 1);
      check("midrst_vsync", int'(vsync), 1);
      check("midrst_rgb", int'({r, g, b}), 0);
      step();
      step();
      RSTN = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (pixel_tick) begin n = i; break; end
      end
      check("midrst_first_tick", n, 4);

      // Line timing: 25 px * 4 clk period, 4 px low
      t_f1 = -1; t_r = -1; t_f2 = -1;
      prev_s = hsync;
      for (int i = 0; i < 400 && t_f2 < 0; i++) begin
         step();
         if (prev_s && !hsync) begin
            if (t_f1 < 0) t_f1 = cyc; else t_f2 = cyc;
         end
         if (!prev_s && hsync && t_f1 >= 0 && t_r < 0) t_r = cyc;
         prev_s = hsync;
      end
      check("hsync_found", int'(t_f2 >= 0), 1);
      check("hsync_period", t_f2 - t_f1, 100);
      check("hsync_low", t_r - t_f1, 16);

      // Frame timing: 10 lines period, 2 lines low, one aligned frame_start
      t_f1 = -1; t_r = -1; t_f2 = -1;
      fs_cnt = 0; fs_bad = 0;
      prev_s = vsync;
      prev_x = pixel_x; prev_y = pixel_y;
      for (int i = 0; i < 3000 && t_f2 < 0; i++) begin
         step();
         if (prev_s && !vsync) begin
            if (t_f1 < 0) t_f1 = cyc; else t_f2 = cyc;
         end
         if (!prev_s && vsync && t_f1 >= 0 && t_r < 0) t_r = cyc;
         if (frame_start && t_f1 >= 0 && t_f2 < 0) begin
            fs_cnt++;
            if (pixel_x != 10'd0 || pixel_y != 10'd0 || prev_x != 10'd24 || prev_y != 10'd9) fs_bad++;
         end
         prev_s = vsync;
         prev_x = pixel_x; prev_y = pixel_y;
      end
      check("vsync_found", int'(t_f2 >= 0), 1);
      check("vsync_period", t_f2 - t_f1, 1000);
      check("vsync_low", t_r - t_f1, 200);
      check("frame_start_count", fs_cnt, 1);
      check("frame_start_pos", fs_bad, 0);

      // Pipeline alignment with the 2-tick RAM
      mode = 0;
      for (int i = 0; i < 1200 && !(pixel_y == 10'd1 && pixel_x == 10'd4); i++) step();
      for (int i = 0; i < 10 && pixel_x != 10'd5; i++) step();
      t0 = cyc; t1 = -1; cnt = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (r && t1 < 0) t1 = cyc;
         if (r) cnt++;
         if (g || b) bad++;
      end
      check("r_latency", t1 - t0, 12);
      check("r_width", cnt, 4);
      check("gb_quiet", bad, 0);

      for (int i = 0; i < 200 && pixel_x != 10'd17; i++) step();
      for (int i = 0; i < 10 && pixel_x != 10'd18; i++) step();
      t0 = cyc; t1 = -1;
      for (int i = 0; i < 40 && t1 < 0; i++) begin
         step();
         if (!hsync) t1 = cyc;
      end
      check("hsync_latency", t1 - t0, 12);

      // Blanking with inputs held high
      run_frame(1, pix_err, lit);
      check("blank_pixel_err", pix_err, 0);
      check("blank_lit", lit, 96);

      // Inputs held low: only the optional border may light
      run_frame(2, pix_err, lit);
      check("dark_pixel_err", pix_err, 0);
`ifdef VGA_BORDER_TEST_EN
      check("dark_lit", lit, 40);
`else
      check("dark_lit", lit, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
